drum_mem_ctrl: RTL

DRUM_MEM_CTRL -- requirements
Module: drum_mem_ctrl

---
 rtl/drum_mem_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/drum_mem_ctrl.sv
// Drum memory controller: a rotating drum store of 2^ADDR_W words, one word
// per sector. A level request from the pulse sequencer is latched in IDLE,
// waits for its sector to pass under the head, transfers, emits a single
// mem_finish pulse and then holds off until both enables drop.
// Build option: define DRUM_LATENCY_EN to model rotational latency; without
// it the head stays parked at sector 0 and every access takes 2 cycles.
module drum_mem_ctrl #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 31,
  parameter int SECTOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_finish,
  output logic              busy,
  output logic [ADDR_W-1:0] drum_pos
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, FINISH, COOL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_wr;
  logic [ADDR_W-1:0]   pos_q;
  logic                hit;
  logic                xfer;

  // Drum contents survive reset; power-up image is all zeros.
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

`ifdef DRUM_LATENCY_EN
  localparam int DIV_W = $clog2(SECTOR_CYCLES);
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(SECTOR_CYCLES - 1));
  assign hit  = tick && (pos_q == lat_addr);

  // Sector divider and head position; position advances on each sector tick.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q <= '0;
      pos_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      pos_q <= pos_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end
`else
  // Head parked at sector 0: every waiting access transfers on its first edge.
  assign pos_q = '0;
  assign hit   = 1'b1;
`endif

  assign xfer     = (state_q == WAIT) && hit;
  assign busy     = (state_q != IDLE);
  assign drum_pos = pos_q;

  // Next-state logic; COOL waits for both enables low so a held level is one access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read_enable || write_enable) state_d = WAIT;
      WAIT:    if (hit) state_d = FINISH;
      FINISH:  state_d = COOL;
      COOL:    if (!read_enable && !write_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, completion pulse and read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mem_finish <= 1'b0;
      rdata      <= '0;
    end else begin
      state_q    <= state_d;
      mem_finish <= (state_q == FINISH);
      if (xfer && !lat_wr) rdata <= mem[lat_addr];
    end
  end

  // Request latch: captured only when leaving IDLE, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (resetn && state_q == IDLE && (read_enable || write_enable)) begin
      lat_addr  <= addr;
      lat_wdata <= wdata;
      lat_wr    <= write_enable;
    end
  end

  // Array write on the transfer edge; reset at that edge aborts the write.
  always_ff @(posedge clk) begin
    if (resetn && xfer && lat_wr) mem[lat_addr] <= lat_wdata;
  end

endmodule
